multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/mc_pkg.sv | 96 +++++++++
 rtl/mc_decode.sv | 56 +++++
 rtl/multicycle_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and encodings for the multicycle sequencer:
//               state enum, instruction classes, opcode/funct constants,
//               ALU operation codes and datapath mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_FAULT    = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_JR   = 4'd1,
        CLS_NORI = 4'd2,
        CLS_LW   = 4'd3,
        CLS_SW   = 4'd4,
        CLS_BLEU = 4'd5,
        CLS_J    = 4'd6,
        CLS_JAL  = 4'd7,
        CLS_BAD  = 4'd8
    } iclass_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_NORI  = 6'b001110;
    localparam logic [5:0] c_OP_BLEU  = 6'b011100;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_F_SLL = 6'b000000;
    localparam logic [5:0] c_F_SRL = 6'b000010;
    localparam logic [5:0] c_F_JR  = 6'b001000;
    localparam logic [5:0] c_F_ADD = 6'b100000;
    localparam logic [5:0] c_F_SUB = 6'b100010;
    localparam logic [5:0] c_F_AND = 6'b100100;
    localparam logic [5:0] c_F_OR  = 6'b100101;
    localparam logic [5:0] c_F_XOR = 6'b100110;
    localparam logic [5:0] c_F_NOR = 6'b100111;
    localparam logic [5:0] c_F_SLT = 6'b101010;

    localparam logic [4:0] c_ALU_ADD  = 5'd0;
    localparam logic [4:0] c_ALU_SUB  = 5'd1;
    localparam logic [4:0] c_ALU_AND  = 5'd2;
    localparam logic [4:0] c_ALU_OR   = 5'd3;
    localparam logic [4:0] c_ALU_XOR  = 5'd4;
    localparam logic [4:0] c_ALU_NOR  = 5'd5;
    localparam logic [4:0] c_ALU_SLT  = 5'd6;
    localparam logic [4:0] c_ALU_SLL  = 5'd7;
    localparam logic [4:0] c_ALU_SRL  = 5'd8;
    localparam logic [4:0] c_ALU_BLEU = 5'd9;

    localparam logic [1:0] c_SRCB_RDB     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] c_PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] c_PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] c_PCSRC_RD1    = 2'b11;

    // Unknown funct codes fall back to ADD; the instruction still retires.
    function automatic logic [4:0] funct_to_alu(input logic [5:0] f);
        case (f)
            c_F_SUB: return c_ALU_SUB;
            c_F_AND: return c_ALU_AND;
            c_F_OR:  return c_ALU_OR;
            c_F_XOR: return c_ALU_XOR;
            c_F_NOR: return c_ALU_NOR;
            c_F_SLT: return c_ALU_SLT;
            c_F_SLL: return c_ALU_SLL;
            c_F_SRL: return c_ALU_SRL;
            default: return c_ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// ============================================================================
// Module      : mc_decode
// Description : Combinational instruction decoder: maps the registered
//               instruction to an instruction class and ALU operation code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] i_instr,
    output iclass_t     o_iclass,
    output logic [4:0]  o_alu_ctrl
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = i_instr[31:26];
    assign w_funct         = i_instr[5:0];
    // Register and immediate fields belong to the datapath, not to control.
    assign w_unused_fields = ^i_instr[25:6];

    always_comb begin
        o_iclass   = CLS_BAD;
        o_alu_ctrl = c_ALU_ADD;
        case (w_opcode)
            c_OP_RTYPE: begin
                if (w_funct == c_F_JR) begin
                    o_iclass = CLS_JR;
                end else begin
                    o_iclass   = CLS_R;
                    o_alu_ctrl = funct_to_alu(w_funct);
                end
            end
            c_OP_NORI: begin
                o_iclass   = CLS_NORI;
                o_alu_ctrl = c_ALU_NOR;
            end
            c_OP_LW:   o_iclass = CLS_LW;
            c_OP_SW:   o_iclass = CLS_SW;
            c_OP_BLEU: begin
                o_iclass   = CLS_BLEU;
                o_alu_ctrl = c_ALU_BLEU;
            end
            c_OP_J:    o_iclass = CLS_J;
            c_OP_JAL:  o_iclass = CLS_JAL;
            default:   o_iclass = CLS_BAD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multicycle control FSM with memory-wait timeout and sticky
//               fault. Define MC_SEQ_PERF_CNT_EN to add cycle_cnt/instr_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_neg,
    output logic        pc_write,
    output logic        iord,
    output logic        ir_write,
    output logic        alu_src_a,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        jump,
    output logic        jump_reg,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [4:0]  alu_control,
    output logic [3:0]  state,
    output logic        fault,
    output logic        retire
`ifdef MC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         r_state;
    state_t         w_next;
    logic [WCW-1:0] r_wait;
    logic           w_waiting;
    logic           w_wait_done;
    iclass_t        w_iclass;
    logic [4:0]     w_alu_dec;
    logic           w_pc_write;
    logic           w_ir_write;
    logic           w_reg_write;
    logic           w_mem_write;
    logic           w_retire;
    logic           w_unused_alu_neg;

    // The branch decision is taken by the datapath mux, not by the FSM.
    assign w_unused_alu_neg = alu_neg;

    mc_decode u_decode (
        .i_instr    (instr),
        .o_iclass   (w_iclass),
        .o_alu_ctrl (w_alu_dec)
    );

    assign w_wait_done = (r_wait == WCW'(MEM_TIMEOUT - 1));
    assign w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                          (r_state == S_MEM_WR)) && !mem_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_waiting) begin
            r_wait <= r_wait + WCW'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_retire    = 1'b0;
        iord        = 1'b0;
        alu_src_a   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
        alu_src_b   = c_SRCB_RDB;
        pc_src      = c_PCSRC_PLUS4;
        alu_control = c_ALU_ADD;
        fault       = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_wait_done) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                // Precompute the branch target while the class is resolved.
                alu_src_b = c_SRCB_IMM_SH2;
                case (w_iclass)
                    CLS_R:                  w_next = S_EXEC_R;
                    CLS_NORI:               w_next = S_EXEC_I;
                    CLS_LW, CLS_SW:         w_next = S_MEM_ADDR;
                    CLS_BLEU:               w_next = S_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR: w_next = S_JUMP;
                    default:                w_next = S_FAULT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_src_b   = c_SRCB_RDB;
                alu_control = w_alu_dec;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = c_SRCB_IMM;
                alu_control = w_alu_dec;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = (w_iclass == CLS_R);
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                w_next    = (w_iclass == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end else if (w_wait_done) begin
                    w_next = S_FAULT;
                end
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_wait_done) begin
                    w_next = S_FAULT;
                end
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_src_b   = c_SRCB_RDB;
                alu_control = c_ALU_BLEU;
                w_pc_write  = 1'b1;
                pc_src      = c_PCSRC_BRANCH;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
                if (w_iclass == CLS_JR) begin
                    pc_src   = c_PCSRC_RD1;
                    jump_reg = 1'b1;
                end else begin
                    pc_src      = c_PCSRC_JUMP;
                    jump        = 1'b1;
                    w_reg_write = (w_iclass == CLS_JAL);
                end
            end
            S_FAULT: begin
                fault  = 1'b1;
                w_next = S_FAULT;
            end
            default: w_next = S_FAULT;
        endcase
    end

    // FETCH is entered during reset; mask its mem_ready-driven strobes too.
    assign pc_write  = w_pc_write  & reset_n;
    assign ir_write  = w_ir_write  & reset_n;
    assign reg_write = w_reg_write & reset_n;
    assign mem_write = w_mem_write & reset_n;
    assign retire    = w_retire    & reset_n;
    assign state     = r_state;

`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer
//               (honours MC_SEQ_PERF_CNT_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;
    import mc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_neg;
    logic        pc_write, iord, ir_write, alu_src_a, reg_write, reg_dst;
    logic        mem_to_reg, mem_write, jump, jump_reg;
    logic [1:0]  alu_src_b, pc_src;
    logic [4:0]  alu_control;
    logic [3:0]  state;
    logic        fault, retire;
`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_retires = 0;

    // {pc_write, ir_write, reg_write, mem_write, iord, retire}
    logic [5:0] w_en;
    assign w_en = {pc_write, ir_write, reg_write, mem_write, iord, retire};

    multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .alu_neg     (alu_neg),
        .pc_write    (pc_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .alu_src_a   (alu_src_a),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .state       (state),
        .fault       (fault),
        .retire      (retire)
`ifdef MC_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] f);
        return {c_OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'h0004};
    endfunction

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        instr     = 32'h0;
        alu_neg   = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("rst_state", state, S_FETCH);
        chk("rst_en", w_en, 6'b000000);
        chk("rst_fault", fault, 1'b0);
`ifdef MC_SEQ_PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instr_cnt", instr_cnt, 32'd0);
`endif

        // R-type add, memory always ready
        reset_n = 1'b1;
        instr   = mk_r(c_F_ADD);
        #1;
        chk("add_c1_state", state, S_FETCH);
        chk("add_c1_en", w_en, 6'b110000);
        chk("add_c1_srcb", alu_src_b, c_SRCB_FOUR);
        chk("add_c1_pcsrc", pc_src, c_PCSRC_PLUS4);
        step;
        chk("add_c2_state", state, S_DECODE);
        chk("add_c2_en", w_en, 6'b000000);
        step;
        chk("add_c3_state", state, S_EXEC_R);
        chk("add_c3_srcb", alu_src_b, c_SRCB_RDB);
        chk("add_c3_alu", alu_control, c_ALU_ADD);
        chk("add_c3_en", w_en, 6'b000000);
        step;
        chk("add_c4_state", state, S_ALU_WB);
        chk("add_c4_en", w_en, 6'b001001);
        chk("add_c4_regdst", reg_dst, 1'b1);
        exp_retires++;

        // lw with three wait cycles in MEM_RD
        step;
        instr = mk_i(c_OP_LW);
        #1;
        chk("lw_c1_en", w_en, 6'b110000);
        step;
        chk("lw_c2_state", state, S_DECODE);
        step;
        chk("lw_c3_state", state, S_MEM_ADDR);
        chk("lw_c3_srcb", alu_src_b, c_SRCB_IMM);
        chk("lw_c3_alu", alu_control, c_ALU_ADD);
        mem_ready = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            step;
            chk($sformatf("lw_c%0d_state", i), state, S_MEM_RD);
            chk($sformatf("lw_c%0d_en", i), w_en, 6'b000010);
        end
        step;
        mem_ready = 1'b1;
        #1;
        chk("lw_c7_state", state, S_MEM_RD);
        chk("lw_c7_en", w_en, 6'b000010);
        step;
        chk("lw_c8_state", state, S_MEM_WB);
        chk("lw_c8_en", w_en, 6'b001001);
        chk("lw_c8_memtoreg", mem_to_reg, 1'b1);
        chk("lw_c8_regdst", reg_dst, 1'b0);
        exp_retires++;

        // sw with two wait cycles in MEM_WR
        step;
        instr = mk_i(c_OP_SW);
        #1;
        chk("sw_c1_en", w_en, 6'b110000);
        step;
        step;
        chk("sw_c3_state", state, S_MEM_ADDR);
        mem_ready = 1'b0;
        step;
        chk("sw_c4_en", w_en, 6'b000110);
        step;
        chk("sw_c5_en", w_en, 6'b000110);
        step;
        mem_ready = 1'b1;
        #1;
        chk("sw_c6_state", state, S_MEM_WR);
        chk("sw_c6_en", w_en, 6'b000111);
        exp_retires++;

        // bleu, taken and not taken
        instr   = mk_i(c_OP_BLEU);
        alu_neg = 1'b1;
        step;
        chk("sw_after_state", state, S_FETCH);
        chk("sw_after_memwrite", mem_write, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step;
            chk($sformatf("bleu%0d_c2_state", k), state, S_DECODE);
            step;
            chk($sformatf("bleu%0d_c3_state", k), state, S_BRANCH);
            chk($sformatf("bleu%0d_c3_en", k), w_en, 6'b100001);
            chk($sformatf("bleu%0d_c3_pcsrc", k), pc_src, c_PCSRC_BRANCH);
            chk($sformatf("bleu%0d_c3_alu", k), alu_control, c_ALU_BLEU);
            exp_retires++;
            alu_neg = 1'b0;
            step;
        end

        // jr
        instr = mk_r(c_F_JR);
        #1;
        step;
        step;
        chk("jr_state", state, S_JUMP);
        chk("jr_en", w_en, 6'b100001);
        chk("jr_pcsrc", pc_src, c_PCSRC_RD1);
        chk("jr_jumps", {jump, jump_reg}, 2'b01);
        exp_retires++;

        // jal
        step;
        instr = mk_i(c_OP_JAL);
        #1;
        step;
        step;
        chk("jal_state", state, S_JUMP);
        chk("jal_en", w_en, 6'b101001);
        chk("jal_pcsrc", pc_src, c_PCSRC_JUMP);
        chk("jal_jumps", {jump, jump_reg}, 2'b10);
        exp_retires++;

        // nori
        step;
        instr = mk_i(c_OP_NORI);
        #1;
        step;
        step;
        chk("nori_state", state, S_EXEC_I);
        chk("nori_srcb", alu_src_b, c_SRCB_IMM);
        chk("nori_alu", alu_control, c_ALU_NOR);
        step;
        chk("nori_wb_en", w_en, 6'b001001);
        chk("nori_wb_regdst", reg_dst, 1'b0);
        exp_retires++;

        // illegal opcode
        step;
        instr = 32'hFC00_0000;
        #1;
        step;
        step;
        chk("bad_state", state, S_FAULT);
        chk("bad_fault", fault, 1'b1);
        chk("bad_en", w_en, 6'b000000);
`ifdef MC_SEQ_PERF_CNT_EN
        chk("instr_cnt", instr_cnt, exp_retires);
`endif
        repeat (3) step;
        chk("bad_absorb", state, S_FAULT);

        // async reset, then FETCH timeout
        reset_n = 1'b0;
        #1;
        chk("bad_rst_state", state, S_FETCH);
        chk("bad_rst_fault", fault, 1'b0);
        step;
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        instr     = mk_r(c_F_ADD);
        #1;
        repeat (15) step;
        chk("to_15_state", state, S_FETCH);
        chk("to_15_en", w_en, 6'b000000);
        step;
        mem_ready = 1'b1;
        #1;
        chk("to_16_state", state, S_FAULT);
        chk("to_16_fault", fault, 1'b1);
        chk("to_16_en", w_en, 6'b000000);
        reset_n = 1'b0;
        #1;
        chk("to_rst_state", state, S_FETCH);
        chk("to_rst_fault", fault, 1'b0);
        chk("to_rst_en", w_en, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
